// File: rtl/adc_pipe_capture_if.sv
// Bus between the capture block and its environment: ADC code in, trigger controls,
// and the valid/ready read port with burst status.
interface adc_pipe_capture_if #(
    parameter int NUM_BITS = 3,
    parameter int DEPTH    = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_BITS-1:0] d_i;
    logic                arm_i;
    logic                trig_i;
    logic                abort_i;
    logic                rd_ready_i;
    logic                rd_valid_o;
    logic [NUM_BITS-1:0] rd_data_o;
    logic                busy_o;
    logic                done_o;
    logic [CW-1:0]       clip_cnt_o;

    modport master (
        output d_i, arm_i, trig_i, abort_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, busy_o, done_o, clip_cnt_o
    );

    modport slave (
        input  d_i, arm_i, trig_i, abort_i, rd_ready_i,
        output rd_valid_o, rd_data_o, busy_o, done_o, clip_cnt_o
    );
endinterface

// File: rtl/adc_pipe_capture.sv
// Burst capture of pipelined-ADC codes: waits out the encoder fill, captures DEPTH codes
// on trigger, counts full-scale codes, and drains the burst over a valid/ready port.
module adc_pipe_capture #(
    parameter int NUM_BITS = 3,
    parameter int DEPTH    = 16,
    parameter int LATENCY  = 3
) (
    input  logic               clock_i,
    input  logic               reset_i,
    adc_pipe_capture_if.slave  bus
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int FILL_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'((LATENCY == 0) ? 0 : LATENCY - 1);
    localparam logic [PW-1:0]       PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [NUM_BITS-1:0] CODE_MAX  = '1;

    typedef enum logic [2:0] {
        S_FILL,
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       clip_cnt_q, clip_cnt_d;
    logic                done_q, done_d;
    logic [NUM_BITS-1:0] mem_q [DEPTH];
    logic                wr_en;
    logic [PW-1:0]       wr_addr;
    logic                is_full_scale;

    assign is_full_scale = (bus.d_i == '0) || (bus.d_i == CODE_MAX);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        clip_cnt_d = clip_cnt_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;
        case (state_q)
            S_FILL: begin
                if (fill_cnt_q == FILL_LAST) state_d = S_IDLE;
                else                         fill_cnt_d = fill_cnt_q + 1'b1;
            end
            S_IDLE: begin
                if (bus.arm_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.abort_i) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (bus.trig_i) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    clip_cnt_d = CW'(is_full_scale);
                    wr_ptr_d   = PW'(1);
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.abort_i) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    wr_en      = 1'b1;
                    clip_cnt_d = clip_cnt_q + CW'(is_full_scale);
                    if (wr_ptr_q == PTR_LAST) begin
                        wr_ptr_d = '0;
                        state_d  = S_READOUT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            S_READOUT: begin
                if (bus.abort_i) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (bus.rd_ready_i) begin
                    // Last word accepted: return to IDLE with a one-cycle done pulse.
                    if (rd_ptr_q == PTR_LAST) begin
                        rd_ptr_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_FILL;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            clip_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            clip_cnt_q <= clip_cnt_d;
            done_q     <= done_d;
        end
    end

    // Sample storage carries no reset; contents are only read after a full burst write.
    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_addr] <= bus.d_i;
    end

    assign bus.busy_o     = (state_q == S_ARMED) || (state_q == S_CAPTURE) || (state_q == S_READOUT);
    assign bus.rd_valid_o = (state_q == S_READOUT);
    assign bus.rd_data_o  = (state_q == S_READOUT) ? mem_q[rd_ptr_q] : '0;
    assign bus.done_o     = done_q;
    assign bus.clip_cnt_o = clip_cnt_q;
endmodule
